// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: IF/ID/EX/MEM/WB/ECALL/HALT with MEM_LAT-stretched memory states.
// Optional macro MC_EX_WB_MERGE_EN: R/I-type instructions write back in EX and skip WB.
module multicycle_control_unit #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       halt,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_source,
    output logic       is_ecall,
    output logic [2:0] state
);
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IF    = 3'd0,
        S_ID    = 3'd1,
        S_EX    = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_ECALL = 3'd5,
        S_HALT  = 3'd6
    } state_t;

    state_t           cur_state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             last_beat;

    assign last_beat = (cnt == LAST_BEAT);
    assign state     = cur_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_IF;
            cnt       <= '0;
        end else begin
            cur_state <= next_state;
            cnt       <= cnt_next;
        end
    end

    // Controls are decoded only while out of reset, so an in-flight store strobe drops at once.
    always_comb begin
        next_state = cur_state;
        cnt_next   = cnt;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 1'b0;
        is_ecall   = 1'b0;
        if (reset) begin
            case (cur_state)
                S_IF: begin
                    mem_read = 1'b1;
                    if (last_beat) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        alu_src_b  = 2'b10;
                        cnt_next   = '0;
                        next_state = S_ID;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                S_ID: begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b01;
                    next_state = (opcode == OP_ECALL) ? S_ECALL : S_EX;
                end
                S_EX: begin
                    next_state = S_IF;
                    case (opcode)
                        OP_ARITH, OP_ARITH_IMM: begin
                            alu_src_a = 2'b01;
                            alu_src_b = (opcode == OP_ARITH_IMM) ? 2'b01 : 2'b00;
                            alu_op    = 2'b01;
`ifdef MC_EX_WB_MERGE_EN
                            reg_write = 1'b1;
                            wb_sel    = 2'b11;
`else
                            next_state = S_WB;
`endif
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_a  = 2'b01;
                            alu_src_b  = 2'b01;
                            next_state = S_MEM;
                        end
                        OP_BRANCH: begin
                            alu_src_a = 2'b01;
                            alu_op    = 2'b10;
                            pc_source = 1'b1;
                            pc_write  = bcond;
                        end
                        OP_JAL: begin
                            pc_write  = 1'b1;
                            pc_source = 1'b1;
                            reg_write = 1'b1;
                            wb_sel    = 2'b10;
                        end
                        OP_JALR: begin
                            alu_src_a = 2'b01;
                            alu_src_b = 2'b01;
                            pc_write  = 1'b1;
                            reg_write = 1'b1;
                            wb_sel    = 2'b10;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = (opcode == OP_LOAD);
                    mem_write = (opcode == OP_STORE);
                    if (last_beat) begin
                        cnt_next   = '0;
                        next_state = (opcode == OP_LOAD) ? S_WB : S_IF;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    wb_sel     = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
                    next_state = S_IF;
                end
                S_ECALL: begin
                    is_ecall   = 1'b1;
                    next_state = halt ? S_HALT : S_IF;
                end
                S_HALT: next_state = S_HALT;
                default: next_state = S_IF;
            endcase
        end
    end
endmodule
